// File: rtl/clk_div_pkg.sv
// Shared constants, state encoding and tap-index clamp for the divided-clock
// tap selector.
package clk_div_pkg;

   localparam int N_TAPS = 22;
   localparam int SEL_W  = 5;

   typedef enum logic [1:0] {
      ST_ARM    = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2
   } tap_state_e;

   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
      if (sel >= SEL_W'(N_TAPS)) return SEL_W'(N_TAPS - 1);
      return sel;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit STAGES-deep synchroniser with synchronous active-high reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_tap_select.sv
// Glitch-free run-time selection of one divided-clock tap, emitted as a
// registered square wave plus a rising-edge TICK strobe. Define PERIOD_MEAS_EN
// to build the tick-to-tick period counter.
module clk_tap_select
   import clk_div_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PER_W       = 24
) (
   input  logic              CLK_IN,
   input  logic              RST_IN,
   input  logic [N_TAPS-1:0] DIV_IN,
   input  logic [SEL_W-1:0]  SEL_IN,
   input  logic              SEL_LOAD,
   output logic              SEL_BUSY,
   output logic [SEL_W-1:0]  ACTIVE_SEL,
   output logic              FREQ_OUT,
   output logic              TICK_OUT,
   output logic [PER_W-1:0]  PERIOD_OUT,
   output logic              PERIOD_VLD
);

   logic [N_TAPS-1:0] sync_q;
   logic              s, s_d;
   tap_state_e        state, state_nxt;
   logic [SEL_W-1:0]  pend_sel, pend_nxt, act_nxt, req_sel;
   logic              busy_nxt, freq_nxt, tick_nxt;

   for (genvar i = 0; i < N_TAPS; i++) begin : g_sync
      sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (CLK_IN),
         .rst (RST_IN),
         .d   (DIV_IN[i]),
         .q   (sync_q[i])
      );
   end

   assign s       = sync_q[ACTIVE_SEL];
   assign req_sel = clamp_sel(SEL_IN);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend_sel;
      act_nxt   = ACTIVE_SEL;
      busy_nxt  = SEL_BUSY;
      freq_nxt  = 1'b0;
      tick_nxt  = 1'b0;
      case (state)
         ST_ARM: begin
            if (!s) begin
               state_nxt = ST_RUN;
               busy_nxt  = 1'b0;
            end
         end
         ST_RUN: begin
            freq_nxt = s;
            tick_nxt = s & ~s_d;
            if (SEL_LOAD && !SEL_BUSY && (req_sel != ACTIVE_SEL)) begin
               pend_nxt  = req_sel;
               busy_nxt  = 1'b1;
               state_nxt = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            // Hold the old tap until its high phase ends so FREQ_OUT is never cut short.
            if (!s) begin
               act_nxt   = pend_sel;
               state_nxt = ST_ARM;
            end else begin
               freq_nxt = s;
               tick_nxt = s & ~s_d;
            end
         end
         default: state_nxt = ST_ARM;
      endcase
   end

   // s_d just tracks s: while parked in ARM s is high, and on the ARM exit
   // cycle s is low, so a rise right after entering RUN is still seen.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         state      <= ST_ARM;
         ACTIVE_SEL <= '0;
         pend_sel   <= '0;
         SEL_BUSY   <= 1'b0;
         FREQ_OUT   <= 1'b0;
         TICK_OUT   <= 1'b0;
         s_d        <= 1'b0;
      end else begin
         state      <= state_nxt;
         ACTIVE_SEL <= act_nxt;
         pend_sel   <= pend_nxt;
         SEL_BUSY   <= busy_nxt;
         FREQ_OUT   <= freq_nxt;
         TICK_OUT   <= tick_nxt;
         s_d        <= s;
      end
   end

`ifdef PERIOD_MEAS_EN
   logic [PER_W-1:0] per_cnt;
   logic             per_seen;

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         per_cnt    <= '0;
         per_seen   <= 1'b0;
         PERIOD_OUT <= '0;
         PERIOD_VLD <= 1'b0;
      end else if (state_nxt != ST_RUN) begin
         per_cnt    <= '0;
         per_seen   <= 1'b0;
         PERIOD_VLD <= 1'b0;
      end else if (tick_nxt) begin
         if (per_seen) begin
            PERIOD_OUT <= (&per_cnt) ? per_cnt : per_cnt + 1'b1;
            PERIOD_VLD <= 1'b1;
         end
         per_cnt  <= '0;
         per_seen <= 1'b1;
      end else if (!(&per_cnt)) begin
         per_cnt <= per_cnt + 1'b1;
      end
   end
`else
   assign PERIOD_OUT = '0;
   assign PERIOD_VLD = 1'b0;
`endif

endmodule
